// File: rtl/smalldiv_iter_pkg.sv
// Shared types and helpers for the iterative runtime-divisor divider.
// State encoding is exported so the debug port and checkers agree on values.
package smalldiv_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must be at least one bit wide even when a single pass suffices.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/smalldiv_iter_step.sv
// One combinational restoring-division step: shift in a dividend bit, try subtracting.
// Invariant rem_in < divisor keeps the restored or reduced remainder within W bits.
module smalldiv_iter_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];

endmodule

// File: rtl/smalldiv_iter.sv
// Iterative unsigned divider with a runtime divisor, BITS_PER_CYCLE restoring steps per clock.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; out_valid holds until taken.
module smalldiv_iter
  import smalldiv_iter_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic [1:0]                dbg_state
);

  localparam int ITER  = DIVIDEND_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(ITER);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [DIVIDEND_WIDTH-1:0]   shift_q;
  logic [DIVIDEND_WIDTH-1:0]   shift_next;
  logic [DIVISOR_WIDTH-1:0]    rem_q;
  logic [DIVISOR_WIDTH-1:0]    div_q;
  logic                        dbz_q;
  logic                        accept;
  logic                        fire;
  logic                        last_iter;

  logic [DIVISOR_WIDTH-1:0]    rem_c [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0]   q_bits;

  // Dividend bits leave the top of shift_q while quotient bits enter at the bottom.
  assign rem_c[0] = rem_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    smalldiv_iter_step #(.W(DIVISOR_WIDTH)) u_step (
      .rem_in  (rem_c[i]),
      .bit_in  (shift_q[DIVIDEND_WIDTH-1-i]),
      .divisor (div_q),
      .rem_out (rem_c[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  assign shift_next = (shift_q << BITS_PER_CYCLE) | DIVIDEND_WIDTH'(q_bits);
  assign last_iter  = (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    fire      = 1'b0;
    out_valid = (state_q == ST_DONE);
    if (enable) begin
      case (state_q)
        ST_IDLE: in_ready = 1'b1;
        ST_DONE: begin
          in_ready = out_ready;
          fire     = out_ready;
        end
        default: ;
      endcase
    end
    accept = in_valid & in_ready;

    case (state_q)
      ST_IDLE: if (accept) state_d = (divisor == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (enable && last_iter) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)    state_d = (divisor == '0) ? ST_DONE : ST_BUSY;
        else if (fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        rem_q <= '0;
        div_q <= divisor;
        if (divisor == '0) begin
          shift_q <= '1;
          dbz_q   <= 1'b1;
        end else begin
          shift_q <= dividend;
          dbz_q   <= 1'b0;
        end
      end else if (enable && state_q == ST_BUSY) begin
        shift_q <= shift_next;
        rem_q   <= rem_c[BITS_PER_CYCLE];
        cnt_q   <= last_iter ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  assign quotient    = shift_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule
